// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared chunk type and index helpers for vec_chunk_fifo
package vec_pkg;

  // Default lane count; the FIFO itself sizes its ports from its own parameter.
  localparam int unsigned WORKING_REGS_DEF = 4;

  // One chunk: WorkingRegs signed int8 lanes, lane 0 in the low byte.
  typedef logic signed [WORKING_REGS_DEF-1:0][7:0] chunk_t;

  // Number of chunks that make up one complete input vector.
  function automatic int unsigned chunks_per_vec(input int unsigned in_vec_length,
                                                 input int unsigned working_regs);
    return in_vec_length / working_regs;
  endfunction

  // Modulo-depth increment with an explicit wrap, so any depth works.
  function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/vec_chunk_fifo.sv
// rtl/vec_chunk_fifo.sv - chunk FIFO with whole-vector ready flag; optional VEC_CHUNK_FIFO_ERR_EN adds sticky error flags
module vec_chunk_fifo
  import vec_pkg::*;
#(
  parameter int unsigned InVecLength = 16,
  parameter int unsigned WorkingRegs = 4,
  parameter int unsigned DepthVecs   = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   wr_en,
  input  logic signed [WorkingRegs-1:0][7:0]     wr_data,
  output logic                                   full,
  input  logic                                   rd_req,
  output logic signed [WorkingRegs-1:0][7:0]     rd_data,
  output logic                                   rd_valid,
  output logic                                   rd_last,
  output logic                                   vec_ready,
  output logic                                   empty,
  output logic [$clog2(DepthVecs*(InVecLength/WorkingRegs)+1)-1:0] count
`ifdef VEC_CHUNK_FIFO_ERR_EN
  ,
  output logic                                   overflow_err,
  output logic                                   underflow_err
`endif
);

  localparam int unsigned ChunksPerVec = chunks_per_vec(InVecLength, WorkingRegs);
  localparam int unsigned Depth        = DepthVecs * ChunksPerVec;
  localparam int unsigned PtrW         = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned IdxW         = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;
  localparam int unsigned CntW         = $clog2(Depth + 1);

  // Plain register array so reads are a mux off flops, no RAM inference.
  logic [WorkingRegs-1:0][7:0] mem [Depth];

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count_q;
  logic [IdxW-1:0] rd_chunk_idx;

  logic pop_acc;
  logic push_acc;

  // Handshake decode: a pop frees a slot, so a full FIFO may still take a push that cycle.
  always_comb begin
    pop_acc  = 1'b0;
    push_acc = 1'b0;
    pop_acc  = rd_req && (count_q != '0);
    push_acc = wr_en && ((count_q != CntW'(Depth)) || pop_acc);
  end

  // Status flags straight off the registered occupancy.
  always_comb begin
    full      = 1'b0;
    empty     = 1'b0;
    vec_ready = 1'b0;
    full      = (count_q == CntW'(Depth));
    empty     = (count_q == '0);
    vec_ready = (count_q >= CntW'(ChunksPerVec));
  end

  assign count = count_q;

  // Storage write; contents survive reset since only pointers define validity.
  always_ff @(posedge clk_in) begin
    if (push_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      rd_chunk_idx <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= PtrW'(ptr_wrap(32'(wr_ptr), Depth));
      end

      if (pop_acc) begin
        // Nonblocking read returns the old entry even when a push reuses this slot.
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_last  <= (rd_chunk_idx == IdxW'(ChunksPerVec - 1));
        rd_ptr   <= PtrW'(ptr_wrap(32'(rd_ptr), Depth));
        rd_chunk_idx <= (rd_chunk_idx == IdxW'(ChunksPerVec - 1)) ? '0
                                                                 : rd_chunk_idx + 1'b1;
      end else begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end

      unique case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef VEC_CHUNK_FIFO_ERR_EN
  // Sticky error flags: dropped pushes and reads of an empty FIFO.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_en && !push_acc) begin
        overflow_err <= 1'b1;
      end
      if (rd_req && (count_q == '0)) begin
        underflow_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vec_chunk_fifo.sv
// tb/tb_vec_chunk_fifo.sv - randomized and directed bench for vec_chunk_fifo against a queue model
module tb_vec_chunk_fifo;
  import vec_pkg::*;

  localparam int DEPTH = 8;
  localparam int CPV   = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        wr_en  = 1'b0;
  chunk_t      wr_data = '0;
  logic        rd_req = 1'b0;
  logic        full;
  chunk_t      rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        vec_ready;
  logic        empty;
  logic [3:0]  count;
`ifdef VEC_CHUNK_FIFO_ERR_EN
  logic        overflow_err;
  logic        underflow_err;
`endif

  vec_chunk_fifo #(.InVecLength(16), .WorkingRegs(4), .DepthVecs(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .vec_ready(vec_ready), .empty(empty), .count(count)
`ifdef VEC_CHUNK_FIFO_ERR_EN
    , .overflow_err(overflow_err), .underflow_err(underflow_err)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a queue of stored chunks plus the registered read outputs.
  logic [31:0] mq[$];
  logic [31:0] m_rd_data = '0;
  bit          m_rd_valid = 0;
  bit          m_rd_last = 0;
  int          m_pops = 0;
  bit          m_ov = 0;
  bit          m_un = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, settle past the edge.
  task automatic cyc(input bit we, input logic [31:0] wd, input bit rr, input bit rs);
    bit pop, push;
    wr_en = we; wr_data = wd; rd_req = rr; rst_in = rs;
    @(posedge clk_in);
    if (rs) begin
      mq.delete(); m_rd_data = '0; m_rd_valid = 0; m_rd_last = 0; m_pops = 0;
      m_ov = 0; m_un = 0;
    end else begin
      pop  = rr && (mq.size() > 0);
      push = we && (mq.size() < DEPTH || pop);
      if (we && !push) m_ov = 1;
      if (rr && mq.size() == 0) m_un = 1;
      if (pop) begin
        m_rd_data  = mq.pop_front();
        m_rd_valid = 1;
        m_rd_last  = (m_pops % CPV) == CPV - 1;
        m_pops++;
      end else begin
        m_rd_valid = 0;
        m_rd_last  = 0;
      end
      if (push) mq.push_back(wd);
    end
    #1;
    wr_en = 0; rd_req = 0; rst_in = 0;
  endtask

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("vec_ready", 32'(vec_ready), 32'(mq.size() >= CPV));
      chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      chk("rd_last", 32'(rd_last), 32'(m_rd_last));
      chk("rd_data", 32'(rd_data), m_rd_data);
`ifdef VEC_CHUNK_FIFO_ERR_EN
      chk("overflow_err", 32'(overflow_err), 32'(m_ov));
      chk("underflow_err", 32'(underflow_err), 32'(m_un));
`endif
    end
  end

  function automatic logic [31:0] rep(input logic [7:0] b);
    return {b, b, b, b};
  endfunction

  initial begin
    logic [31:0] held;
    int lasts;

    // Reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_vec_ready", 32'(vec_ready), 32'd0);

    // Basic vector: four chunks in, four out, rd_last on the fourth
    for (int i = 1; i <= 4; i++) begin
      chk("pre_vec_ready", 32'(vec_ready), 32'd0);
      cyc(1, rep(8'(i)), 0, 0);
    end
    chk("basic_count", 32'(count), 32'd4);
    chk("basic_vec_ready", 32'(vec_ready), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1, 0);
      chk("basic_data", 32'(rd_data), rep(8'(i)));
      chk("basic_last", 32'(rd_last), 32'(i == 4));
    end
    chk("basic_empty", 32'(empty), 32'd1);

    // Full and drop: ninth push is discarded
    for (int i = 0; i < 9; i++) cyc(1, rep(8'(8'h10 + i)), 0, 0);
    chk("drop_count", 32'(count), 32'd8);
    chk("drop_full", 32'(full), 32'd1);
`ifdef VEC_CHUNK_FIFO_ERR_EN
    chk("drop_ovf", 32'(overflow_err), 32'd1);
`endif

    // Full with simultaneous push and pop: oldest out, 0xAA lands in the freed slot
    cyc(1, rep(8'hAA), 1, 0);
    chk("fpp_count", 32'(count), 32'd8);
    chk("fpp_data", 32'(rd_data), rep(8'h10));
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    chk("fpp_aa_8th", 32'(rd_data), rep(8'hAA));
    chk("fpp_empty", 32'(empty), 32'd1);

    // Empty read: nothing pops, rd_data holds
    held = 32'(rd_data);
    cyc(0, 0, 1, 0);
    chk("er_valid", 32'(rd_valid), 32'd0);
    chk("er_hold", 32'(rd_data), held);
`ifdef VEC_CHUNK_FIFO_ERR_EN
    chk("er_unf", 32'(underflow_err), 32'd1);
`endif

    // Empty plus push plus rd_req: no bypass, data poppable next cycle
    cyc(1, 32'h5A5A5A5A, 1, 0);
    chk("nobyp_valid", 32'(rd_valid), 32'd0);
    cyc(0, 0, 1, 0);
    chk("nobyp_data", 32'(rd_data), 32'h5A5A5A5A);

    // Wrap-around streaming, 1-cycle lag
    cyc(0, 0, 0, 1);
    lasts = 0;
    for (int i = 0; i <= 20; i++) begin
      cyc(i < 20, $urandom, i > 0, 0);
      if (rd_last) lasts++;
    end
    chk("wrap_lasts", 32'(lasts), 32'd5);

    // Reset mid-vector, then a fresh vector frames from chunk 0
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_valid", 32'(rd_valid), 32'd0);
    chk("mid_last", 32'(rd_last), 32'd0);
    chk("mid_vec_ready", 32'(vec_ready), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1, 0);
      chk("mid_new_last", 32'(rd_last), 32'(i == 4));
    end

    // Randomized traffic with rare resets
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 100) < 55, $urandom, ($urandom % 100) < 50, ($urandom % 500) == 0);
    end

    @(posedge clk_in);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_chunk_fifo.md
Name: vec_chunk_fifo

Overview:
- Chunk-granular FIFO directly upstream of the bias stage; buffers WorkingRegs-wide signed int8 chunks produced by the matrix-vector stage.
- Asserts vec_ready only when at least one whole InVecLength vector is stored, so the consumer can stream a full vector without stalling.
- Reads complete in a single cycle (registered output), which is the read latency the bias stage requires.

Parameters:
- InVecLength, 16, elements per vector; must be a multiple of WorkingRegs.
- WorkingRegs, 4, int8 lanes per chunk.
- DepthVecs, 2, capacity in whole vectors, minimum 1; Depth = DepthVecs*InVecLength/WorkingRegs chunks.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; synchronous, active-high.
- wr_en  input  1  push wr_data this cycle.
- wr_data  input  signed [WorkingRegs-1:0][7:0]  chunk to push.
- full  output  1  count == Depth.
- rd_req  input  1  pop one chunk (driven by consumer req_chunk_in).
- rd_data  output  signed [WorkingRegs-1:0][7:0]  popped chunk, registered.
- rd_valid  output  1  rd_data holds a chunk popped on the previous cycle.
- rd_last  output  1  qualifies rd_valid; chunk is the final chunk of its vector.
- vec_ready  output  1  count >= ChunksPerVec.
- empty  output  1  count == 0.
- count  output  $clog2(Depth+1)  chunks stored.

Behaviour:
- Clock and reset are fixed: one clock, clk_in; rst_in is synchronous, active-high.
- Constants: ChunksPerVec = InVecLength/WorkingRegs.
- Storage is a Depth x (WorkingRegs*8) register array; no RAM primitive.
- State: wr_ptr, rd_ptr (mod Depth, explicit wrap at Depth-1 to 0, not power-of-two reliant), count, rd_chunk_idx (0..ChunksPerVec-1).
- Reset (any cycle, including mid-vector): pointers, count and rd_chunk_idx = 0; rd_data = 0; rd_valid = 0; rd_last = 0; full = 0; empty = 1; vec_ready = 0; stored contents are not cleared.
- Push accepted iff wr_en && (!full || pop_accepted). Accepted push writes mem[wr_ptr] and advances wr_ptr.
- Push when full with no pop that cycle: data dropped, pointers and count unchanged.
- Pop accepted iff rd_req && !empty. Next cycle: rd_data = mem[rd_ptr] (old value), rd_valid = 1, rd_last = (rd_chunk_idx == ChunksPerVec-1). rd_ptr advances and rd_chunk_idx wraps to 0 after the last chunk.
- rd_req while empty: no pop; rd_valid = 0 next cycle; rd_data holds its previous value.
- Simultaneous accepted push and pop: count unchanged. Full plus push plus pop is legal (write lands in the slot being freed), and the popped data is the old entry.
- Empty plus push plus rd_req: no pop this cycle, because there is no same-cycle bypass. The chunk is available next cycle.
- full, empty, vec_ready and count are combinational from registered count and reflect state after the last edge.
- Latency: a pushed chunk is poppable the next cycle; rd_req to rd_data is 1 cycle.
- Vector framing is implicit and positional. The consumer must pop ChunksPerVec chunks per vector; rd_last marks the boundary for checking.

Optional Feature:
- Macro: VEC_CHUNK_FIFO_ERR_EN.
- Defined: adds output ports overflow_err (1) and underflow_err (1), both sticky.
  - overflow_err sets on a dropped push.
  - underflow_err sets on rd_req while empty.
  - Both clear only on rst_in; reset value 0.
- Undefined: the ports do not exist, and dropped pushes and empty reads are silent, with the behaviour above otherwise unchanged.

Decomposition:
- Shared package vec_pkg holds:
  - typedef chunk_t: logic signed [WorkingRegs-1:0][7:0], parameterised via localparam default.
  - a function computing ChunksPerVec.
  - a ptr_wrap helper for non-power-of-two increment.
- No sub-module: storage and control stay in one module.

Test Plan:
- Basic vector (InVecLength=16, WorkingRegs=4, DepthVecs=2): push chunks 0x01..0x04 per lane over 4 cycles.
  - vec_ready rises the cycle after the 4th push, count=4.
  - Assert rd_req 4 cycles: rd_data returns the same chunks in order, rd_valid 4 cycles, rd_last only on the 4th; empty=1 afterwards.
- Full and drop: push 9 chunks with no reads.
  - full=1 after the 8th push; the 9th is dropped, count stays 8.
  - With ERR_EN, overflow_err=1.
- Full with simultaneous push and pop: at count=8, push chunk 0xAA and pop in the same cycle.
  - count stays 8; the popped chunk is the oldest entry.
  - 0xAA emerges as the 8th subsequent pop.
- Wrap-around: stream 20 chunks, pushing and popping each cycle with 1-cycle lag.
  - Output order matches input order across pointer wrap.
  - rd_last on every 4th valid.
- Empty read: rd_req with count=0.
  - rd_valid=0, rd_data unchanged, count=0.
  - With ERR_EN, underflow_err=1.
- Reset mid-operation: assert rst_in after 2 of 4 chunks of a vector are popped.
  - Next cycle count=0, empty=1, rd_valid=0, rd_last=0, vec_ready=0.
  - Next vector pushed reads out with rd_last on its 4th chunk.
